// File: rtl/esram_pkt_buf.sv
// ---------------------------------------------------------------------------
// esram_pkt_buf
//
// Packet buffer built around a large single-clock memory with a fixed-latency
// read path. Accepted reads travel through a RD_LATENCY-deep valid/data
// pipeline and land in a show-ahead response FIFO. A credit counter reserves
// a FIFO slot at accept time, so the FIFO can never overflow no matter how
// long the consumer stalls.
//
// Configuration macro:
//   ESRAM_RAW_BYPASS_EN  defined   -> a read and a write to the same address
//                                     in the same cycle return the new data
//                        undefined -> the same case returns the old contents
//
// Ports:
//   clk_esram     in   1        sole clock
//   rst           in   1        synchronous active-high reset
//   wren          in   1        write strobe (never stalled)
//   wraddress     in   AWIDTH   write address
//   wrdata        in   DWIDTH   write data
//   rd_req_valid  in   1        read request
//   rd_req_ready  out  1        a read can be accepted (credits available)
//   rdaddress     in   AWIDTH   read address, sampled in the accept cycle
//   rd_valid      out  1        response FIFO not empty
//   rd_ready      in   1        consumer pops the head response
//   rddata        out  DWIDTH   head response data
//   stat_rd_req   out  32       count of accepted reads (wrapping)
//   stat_rd_resp  out  32       count of popped responses (wrapping)
// ---------------------------------------------------------------------------
module esram_pkt_buf #(
    parameter int DWIDTH     = 520,
    parameter int AWIDTH     = 17,
    parameter int NCH        = 8,
    parameter int RD_LATENCY = 12,
    parameter int FIFO_DEPTH = 32
) (
    input  logic              clk_esram,
    input  logic              rst,
    input  logic              wren,
    input  logic [AWIDTH-1:0] wraddress,
    input  logic [DWIDTH-1:0] wrdata,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [AWIDTH-1:0] rdaddress,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DWIDTH-1:0] rddata,
    output logic [31:0]       stat_rd_req,
    output logic [31:0]       stat_rd_resp
);

    // Physical word: NCH lanes of 72 bits each
    localparam int MW    = NCH * 72;
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int DEPTH = 2 ** AWIDTH;

    logic [MW-1:0]     mem [DEPTH];
    logic [MW-1:0]     wr_word;
    logic [MW-1:0]     mem_rd;
    logic [DWIDTH-1:0] read_word;

    logic              wr_en;
    logic              accept;
    logic              pop;
    logic              push_valid;
    logic [DWIDTH-1:0] push_data;

    logic [CW-1:0]     credits;

    logic [DWIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              fifo_full;

    // Inputs are ignored while reset is asserted
    assign wr_en        = wren && !rst;
    assign rd_req_ready = (credits != '0);
    assign accept       = rd_req_valid && rd_req_ready && !rst;
    assign rd_valid     = (count != '0);
    assign pop          = rd_valid && rd_ready;
    assign fifo_full    = (count == CW'(FIFO_DEPTH));
    assign rddata       = fifo_mem[rd_ptr];

    // Lane i takes wrdata[72i+71:72i]; the unused top of the last lane is 0
    always_comb begin
        wr_word = '0;
        for (int i = 0; i < NCH; i++) begin
            for (int b = 0; b < 72; b++) begin
                if (i * 72 + b < DWIDTH) begin
                    wr_word[i * 72 + b] = wrdata[i * 72 + b];
                end
            end
        end
    end

    // Memory write port; contents are deliberately not touched by reset
    always_ff @(posedge clk_esram) begin
        if (wr_en) begin
            mem[wraddress] <= wr_word;
        end
    end

    assign mem_rd = mem[rdaddress];

    // Padding bits of the top lane are ignored on read
    generate
        if (MW > DWIDTH) begin : g_pad
            logic unused_pad;
            assign unused_pad = ^mem_rd[MW-1:DWIDTH];
        end
    endgenerate

    // Read data sampled in the accept cycle. With the bypass the write data
    // overrides a colliding read; without it the register update lands after
    // the read, giving the old contents.
    always_comb begin
        read_word = mem_rd[DWIDTH-1:0];
`ifdef ESRAM_RAW_BYPASS_EN
        if (wr_en && (wraddress == rdaddress)) begin
            read_word = wrdata;
        end
`endif
    end

    // Fixed-latency read pipeline. The FIFO write itself is the last stage,
    // so RD_LATENCY-1 register stages precede it.
    generate
        if (RD_LATENCY == 1) begin : g_lat1
            assign push_valid = accept;
            assign push_data  = read_word;
        end else begin : g_pipe
            logic              pipe_valid [RD_LATENCY-1];
            logic [DWIDTH-1:0] pipe_data  [RD_LATENCY-1];

            // Valid bits are reset so in-flight reads vanish on reset
            always_ff @(posedge clk_esram) begin
                if (rst) begin
                    for (int i = 0; i < RD_LATENCY - 1; i++) begin
                        pipe_valid[i] <= 1'b0;
                    end
                end else begin
                    pipe_valid[0] <= accept;
                    for (int i = 1; i < RD_LATENCY - 1; i++) begin
                        pipe_valid[i] <= pipe_valid[i-1];
                    end
                end
            end

            // Data shifts alongside; qualified only by the valid bits
            always_ff @(posedge clk_esram) begin
                if (accept) begin
                    pipe_data[0] <= read_word;
                end
                for (int i = 1; i < RD_LATENCY - 1; i++) begin
                    pipe_data[i] <= pipe_data[i-1];
                end
            end

            assign push_valid = pipe_valid[RD_LATENCY-2];
            assign push_data  = pipe_data[RD_LATENCY-2];
        end
    endgenerate

    // Credits count FIFO slots not yet claimed by an accepted read
    always_ff @(posedge clk_esram) begin
        if (rst) begin
            credits <= CW'(FIFO_DEPTH);
        end else begin
            case ({accept, pop})
                2'b10:   credits <= credits - CW'(1);
                2'b01:   credits <= credits + CW'(1);
                default: credits <= credits;
            endcase
        end
    end

    // Response FIFO storage
    always_ff @(posedge clk_esram) begin
        if (push_valid && !rst) begin
            fifo_mem[wr_ptr] <= push_data;
        end
    end

    // FIFO pointers wrap naturally because the depth is a power of two
    always_ff @(posedge clk_esram) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_valid) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_valid, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Statistics counters wrap at 2^32
    always_ff @(posedge clk_esram) begin
        if (rst) begin
            stat_rd_req  <= '0;
            stat_rd_resp <= '0;
        end else begin
            if (accept) begin
                stat_rd_req <= stat_rd_req + 32'd1;
            end
            if (pop) begin
                stat_rd_resp <= stat_rd_resp + 32'd1;
            end
        end
    end

    // Credits make these unreachable; they flag a broken credit loop
    a_no_overflow: assert property (@(posedge clk_esram) disable iff (rst)
        !(push_valid && fifo_full && !pop));
    a_credit_range: assert property (@(posedge clk_esram) disable iff (rst)
        (credits <= CW'(FIFO_DEPTH)));

endmodule
